// File: rtl/exec_control.sv
// exec_control: execution sequencer for the teaching CPU.
// Turns one-shot push-switch pulses into a registered clock-enable stream for the multicycle
// core. It supports free run with an optional divider, instruction step, clock step and a
// PC breakpoint.
//
// Ports:
//   clk, rst     system clock, asynchronous active-low reset
//   psw_out      one-clk switch pulses: [0] run/stop, [1] inst step, [2] clock step,
//                [3] breakpoint enable toggle, [5] brk_addr+1, [10] brk_addr-1
//   cpu_pc       CPU program counter (valid at phase 0)
//   cpu_halt     CPU has executed HLT
//   cpu_ce       registered CPU clock enable
//   phase        current phase index within the instruction
//   inst_count   completed-instruction counter (wraps)
//   running      high in RUN or DRAIN
//   halted       high in HALTED
//   brk_en       breakpoint enable
//   brk_addr     breakpoint PC
//   brk_hit      sticky: last stop was caused by the breakpoint
module exec_control #(
  parameter int unsigned CYCLES_PER_INST = 4,
  parameter int unsigned RUN_DIV         = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] psw_out,
  input  logic [7:0]  cpu_pc,
  input  logic        cpu_halt,
  output logic        cpu_ce,
  output logic [2:0]  phase,
  output logic [15:0] inst_count,
  output logic        running,
  output logic        halted,
  output logic        brk_en,
  output logic [7:0]  brk_addr,
  output logic        brk_hit
);

  localparam logic [2:0]  LastPhase = 3'(CYCLES_PER_INST - 1);
  localparam logic [15:0] RunDiv    = 16'(RUN_DIV);

  typedef enum logic [2:0] {
    StStop,
    StRun,
    StDrain,
    StIstep,
    StCstep,
    StHalted
  } state_e;

  state_e      state_q, state_d;
  logic        ce_q, ce_d;
  logic [2:0]  phase_q, phase_d;
  logic [15:0] count_q, count_d;
  logic [15:0] div_q, div_d;
  logic        skip_q, skip_d;
  logic        hit_q, hit_d;
  logic        en_q, en_d;
  logic [7:0]  addr_q, addr_d;

  logic        sw_run, sw_istep, sw_cstep, sw_brk_en, sw_inc, sw_dec;
  logic        wrap;
  logic [15:0] div_cur;
  logic        tick;
  logic        issuing_state;

  assign sw_run    = psw_out[0];
  assign sw_istep  = psw_out[1];
  assign sw_cstep  = psw_out[2];
  assign sw_brk_en = psw_out[3];
  assign sw_inc    = psw_out[5];
  assign sw_dec    = psw_out[10];

  logic unused_psw;
  assign unused_psw = ^{psw_out[19:11], psw_out[9:6], psw_out[4]};

  // Phase and instruction counter follow the enable that was issued this cycle.
  always_comb begin
    wrap    = ce_q && (phase_q == LastPhase);
    phase_d = phase_q;
    count_d = count_q;
    if (ce_q) begin
      phase_d = wrap ? 3'd0 : phase_q + 3'd1;
    end
    if (wrap) begin
      count_d = count_q + 16'd1;
    end
  end

  // Breakpoint registers act in every state; simultaneous +1/-1 cancel.
  always_comb begin
    en_d   = en_q ^ sw_brk_en;
    addr_d = addr_q;
    if (sw_inc && !sw_dec) begin
      addr_d = addr_q + 8'd1;
    end else if (sw_dec && !sw_inc) begin
      addr_d = addr_q - 8'd1;
    end
  end

  // Sequencer. ce_d is the enable for the cycle after this edge; phase_d is the phase that
  // cycle will carry, so "phase-0 issue" means ce_d with phase_d == 0.
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    div_d   = div_q;
    skip_d  = skip_q;
    hit_d   = hit_q;
    // Entering RUN evaluates the divider as if it were already 0, so RUN_DIV=D gives the
    // first enable D+1 cycles after the pulse.
    div_cur       = (state_q == StRun) ? div_q : 16'd0;
    tick          = (div_cur == RunDiv);
    issuing_state = (state_q == StRun) || (state_q == StDrain) ||
                    (state_q == StIstep) || (state_q == StCstep);

    unique case (state_q)
      StStop: begin
        if (sw_run) begin
          state_d = StRun;
          skip_d  = 1'b1;
          hit_d   = 1'b0;
          if (tick) begin
            ce_d  = 1'b1;
            div_d = 16'd0;
            if (phase_d == 3'd0) begin
              skip_d = 1'b0;
            end
          end else begin
            div_d = 16'd1;
          end
        end else if (sw_istep) begin
          state_d = StIstep;
          ce_d    = 1'b1;
        end else if (sw_cstep) begin
          state_d = StCstep;
          ce_d    = 1'b1;
        end
      end
      StRun: begin
        if (sw_run) begin
          if (phase_q == 3'd0 && !ce_q) begin
            state_d = StStop;
          end else begin
            state_d = StDrain;
            ce_d    = (phase_d != 3'd0);
          end
        end else if (tick) begin
          if (phase_d == 3'd0 && en_q && cpu_pc == addr_q && !skip_q) begin
            state_d = StStop;
            hit_d   = 1'b1;
          end else begin
            ce_d  = 1'b1;
            div_d = 16'd0;
            if (phase_d == 3'd0) begin
              skip_d = 1'b0;
            end
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      StDrain, StIstep: begin
        if (phase_d == 3'd0) begin
          state_d = StStop;
        end else begin
          ce_d = 1'b1;
        end
      end
      StCstep: begin
        state_d = StStop;
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StStop;
      end
    endcase

    // The halt check catches the instruction boundary before the CPU is clocked again.
    if (issuing_state && ce_d && phase_d == 3'd0 && cpu_halt) begin
      state_d = StHalted;
      ce_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StStop;
      ce_q    <= 1'b0;
      phase_q <= 3'd0;
      count_q <= 16'd0;
      div_q   <= 16'd0;
      skip_q  <= 1'b0;
      hit_q   <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      phase_q <= phase_d;
      count_q <= count_d;
      div_q   <= div_d;
      skip_q  <= skip_d;
      hit_q   <= hit_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
    end
  end

  assign cpu_ce     = ce_q;
  assign phase      = phase_q;
  assign inst_count = count_q;
  assign running    = (state_q == StRun) || (state_q == StDrain);
  assign halted     = (state_q == StHalted);
  assign brk_en     = en_q;
  assign brk_addr   = addr_q;
  assign brk_hit    = hit_q;

endmodule

// File: tb/tb_exec_control.sv
// Directed testbench for exec_control with CYCLES_PER_INST=4, RUN_DIV=2.
module tb_exec_control;

  localparam int unsigned Cpi = 4;
  localparam int unsigned Div = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] psw = '0;
  logic [7:0]  cpu_pc;
  logic        cpu_halt = 1'b0;
  logic        cpu_ce;
  logic [2:0]  phase;
  logic [15:0] inst_count;
  logic        running;
  logic        halted;
  logic        brk_en;
  logic [7:0]  brk_addr;
  logic        brk_hit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // The bench CPU model: PC equals the number of completed instructions.
  assign cpu_pc = inst_count[7:0];

  exec_control #(
    .CYCLES_PER_INST(Cpi),
    .RUN_DIV        (Div)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psw_out   (psw),
    .cpu_pc    (cpu_pc),
    .cpu_halt  (cpu_halt),
    .cpu_ce    (cpu_ce),
    .phase     (phase),
    .inst_count(inst_count),
    .running   (running),
    .halted    (halted),
    .brk_en    (brk_en),
    .brk_addr  (brk_addr),
    .brk_hit   (brk_hit)
  );

  // Called at a negedge; the pulse is sampled by the next posedge, returns at the following
  // negedge (first cycle after the pulse).
  task automatic pulse(input logic [19:0] bits);
    psw = bits;
    @(negedge clk);
    psw = '0;
  endtask

  task automatic count_ce(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (cpu_ce === 1'b1) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    psw      = '0;
    cpu_halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] snap;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    snap = {cpu_ce, phase, inst_count, running, halted, brk_en, brk_addr, brk_hit};
    checks++;
    if (snap !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got %h want 00000000", snap);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    snap = {cpu_ce, phase, inst_count, running, halted, brk_en, brk_addr, brk_hit};
    checks++;
    if (snap !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h want 00000000", snap);
    end
  endtask

  task automatic test_istep();
    logic       exp_ce;
    logic [2:0] exp_ph;
    do_reset();
    pulse(20'h00002);
    for (int i = 0; i < 6; i++) begin
      exp_ce = (i < 4);
      exp_ph = (i < 4) ? 3'(i) : 3'd0;
      checks++;
      if (cpu_ce !== exp_ce || phase !== exp_ph) begin
        errors++;
        $display("FAIL istep_cycle%0d: ce=%b phase=%0d want ce=%b phase=%0d",
                 i, cpu_ce, phase, exp_ce, exp_ph);
      end
      @(negedge clk);
    end
    checks++;
    if (inst_count !== 16'd1 || running !== 1'b0) begin
      errors++;
      $display("FAIL istep_done: inst_count=%0d running=%b want 1 0", inst_count, running);
    end
  endtask

  task automatic test_cstep();
    int c;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      pulse(20'h00004);
      count_ce(5, c);
      checks++;
      if (c !== 1) begin
        errors++;
        $display("FAIL cstep%0d_enables: got %0d want 1", s, c);
      end
    end
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL cstep_phase: got %0d want 3", phase);
    end
    pulse(20'h00002);
    count_ce(5, c);
    checks++;
    if (c !== 1 || inst_count !== 16'd1 || phase !== 3'd0) begin
      errors++;
      $display("FAIL istep_finish: enables=%0d inst_count=%0d phase=%0d want 1 1 0",
               c, inst_count, phase);
    end
  endtask

  task automatic test_run_drain();
    int   c;
    logic exp_ce;
    do_reset();
    pulse(20'h00001);
    // Enables land in every third cycle, first one D+1 cycles after the pulse.
    for (int i = 0; i < 30; i++) begin
      exp_ce = ((i % 3) == 2);
      checks++;
      if (cpu_ce !== exp_ce || running !== 1'b1) begin
        errors++;
        $display("FAIL run_cycle%0d: ce=%b running=%b want ce=%b running=1",
                 i, cpu_ce, running, exp_ce);
      end
      @(negedge clk);
    end
    checks++;
    if (phase !== 3'd2 || cpu_ce !== 1'b0) begin
      errors++;
      $display("FAIL run_before_stop: phase=%0d ce=%b want 2 0", phase, cpu_ce);
    end
    pulse(20'h00001);
    count_ce(5, c);
    checks++;
    if (c !== 2 || phase !== 3'd0 || running !== 1'b0 || inst_count !== 16'd3) begin
      errors++;
      $display("FAIL drain: enables=%0d phase=%0d running=%b inst=%0d want 2 0 0 3",
               c, phase, running, inst_count);
    end
  endtask

  task automatic test_breakpoint();
    int n;
    do_reset();
    repeat (3) pulse(20'h00020);
    pulse(20'h00008);
    checks++;
    if (brk_addr !== 8'h03 || brk_en !== 1'b1) begin
      errors++;
      $display("FAIL brk_setup: addr=%h en=%b want 03 1", brk_addr, brk_en);
    end
    pulse(20'h00001);
    n = 0;
    while (running !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL brk_timeout: running=%b after %0d cycles want 0", running, n);
    end
    checks++;
    if (brk_hit !== 1'b1 || inst_count !== 16'd3 || phase !== 3'd0 || cpu_ce !== 1'b0) begin
      errors++;
      $display("FAIL brk_stop: hit=%b inst=%0d phase=%0d ce=%b want 1 3 0 0",
               brk_hit, inst_count, phase, cpu_ce);
    end
    pulse(20'h00020);
    checks++;
    if (brk_hit !== 1'b1 || brk_addr !== 8'h04) begin
      errors++;
      $display("FAIL brk_hit_sticky: hit=%b addr=%h want 1 04", brk_hit, brk_addr);
    end
    pulse(20'h00400);
    pulse(20'h00001);
    n = 0;
    while (inst_count !== 16'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200 || running !== 1'b1 || brk_hit !== 1'b0) begin
      errors++;
      $display("FAIL brk_resume: inst=%0d running=%b hit=%b want 4 1 0",
               inst_count, running, brk_hit);
    end
  endtask

  task automatic test_brk_wrap();
    do_reset();
    pulse(20'h00400);
    checks++;
    if (brk_addr !== 8'hFF) begin
      errors++;
      $display("FAIL brk_dec_wrap: got %h want ff", brk_addr);
    end
    pulse(20'h00420);
    checks++;
    if (brk_addr !== 8'hFF) begin
      errors++;
      $display("FAIL brk_inc_dec_same: got %h want ff", brk_addr);
    end
    pulse(20'h00020);
    checks++;
    if (brk_addr !== 8'h00) begin
      errors++;
      $display("FAIL brk_inc_wrap: got %h want 00", brk_addr);
    end
    pulse(20'h00008);
    pulse(20'h00008);
    checks++;
    if (brk_en !== 1'b0) begin
      errors++;
      $display("FAIL brk_en_toggle: got %b want 0", brk_en);
    end
  endtask

  task automatic test_priority();
    int c;
    do_reset();
    // Instruction step wins over clock step.
    pulse(20'h00006);
    count_ce(6, c);
    checks++;
    if (c !== 4 || inst_count !== 16'd1) begin
      errors++;
      $display("FAIL prio_istep: enables=%0d inst=%0d want 4 1", c, inst_count);
    end
    pulse(20'h00003);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL prio_run: running=%b want 1", running);
    end
  endtask

  task automatic test_halt();
    int          n;
    int          c;
    logic [31:0] snap;
    do_reset();
    pulse(20'h00001);
    n = 0;
    while (!(inst_count === 16'd1 && phase === 3'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    cpu_halt = 1'b1;
    n = 0;
    while (halted !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL halt_timeout: halted=%b want 1", halted);
    end
    checks++;
    if (inst_count !== 16'd2 || phase !== 3'd0 || cpu_ce !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_entry: inst=%0d phase=%0d ce=%b running=%b want 2 0 0 0",
               inst_count, phase, cpu_ce, running);
    end
    count_ce(6, c);
    pulse(20'h00001);
    count_ce(4, n);
    c += n;
    pulse(20'h00002);
    count_ce(4, n);
    c += n;
    pulse(20'h00004);
    count_ce(4, n);
    c += n;
    checks++;
    if (c !== 0 || halted !== 1'b1 || phase !== 3'd0 || inst_count !== 16'd2) begin
      errors++;
      $display("FAIL halt_ignores: enables=%0d halted=%b phase=%0d inst=%0d want 0 1 0 2",
               c, halted, phase, inst_count);
    end
    pulse(20'h00020);
    checks++;
    if (brk_addr !== 8'h01 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_brk_addr: addr=%h halted=%b want 01 1", brk_addr, halted);
    end
    #2 rst = 1'b0;
    #1;
    snap = {cpu_ce, phase, inst_count, running, halted, brk_en, brk_addr, brk_hit};
    checks++;
    if (snap !== 32'h0) begin
      errors++;
      $display("FAIL halt_async_reset: got %h want 00000000", snap);
    end
    cpu_halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_istep();
    test_cstep();
    test_run_drain();
    test_breakpoint();
    test_brk_wrap();
    test_priority();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_control.md
# exec_control

Execution sequencer for the teaching CPU on the FPGA board. It turns one-cycle push-switch pulses into a clock-enable stream for the multicycle CPU core. Supported modes are free run (optionally slowed), single-instruction step, single-clock step, and stop on a programmable PC breakpoint. It sits between the switch one-shot block and the CPU core, alongside the display-mode controller, and owns all `cpu_ce` generation.

## Interface
- `CYCLES_PER_INST`, default 4: CPU clock phases per instruction; legal range 1..8.
- `RUN_DIV`, default 0: in RUN, `cpu_ce` is issued once every `RUN_DIV+1` clk cycles; legal range 0..65535.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `psw_out`, input, 20: one-clk pulses from the switch one-shot block.
  - Used bits: [0] RUN/STOP toggle, [1] instruction step, [2] clock step, [3] breakpoint-enable toggle, [5] `brk_addr`+1, [10] `brk_addr`-1.
  - All other bits are ignored.
- `cpu_pc`, input, 8: CPU program counter; valid whenever `phase`==0.
- `cpu_halt`, input, 1: level; the CPU has executed HLT.
- `cpu_ce`, output, 1: registered CPU clock enable.
- `phase`, output, 3: current phase index, 0..`CYCLES_PER_INST`-1.
- `inst_count`, output, 16: completed-instruction counter; wraps.
- `running`, output, 1: high in RUN or DRAIN.
- `halted`, output, 1: high in HALTED.
- `brk_en`, output, 1: breakpoint enabled.
- `brk_addr`, output, 8: breakpoint PC.
- `brk_hit`, output, 1: sticky flag; the last stop was caused by the breakpoint.

## Operation
- **Reset values:**
  - state STOP;
  - `cpu_ce`=0, `phase`=0, `inst_count`=0;
  - `running`=0, `halted`=0, `brk_en`=0, `brk_addr`=0, `brk_hit`=0;
  - divider=0, `skip_brk`=0.
- **Phase counter:**
  - Advances by 1 on every clk in which `cpu_ce`=1.
  - After `CYCLES_PER_INST`-1 it wraps to 0 and `inst_count` increments (16-bit wrap, 0xFFFF→0).
- **States:** STOP, RUN, DRAIN, ISTEP, CSTEP, HALTED.
- **STOP:**
  - psw[0] → RUN, divider=0, `skip_brk`=1, `brk_hit` cleared.
  - Otherwise psw[1] → ISTEP.
  - Otherwise psw[2] → CSTEP.
  - Priority when pulses coincide: [0] > [1] > [2].
- **RUN:**
  - Issues `cpu_ce` when the divider reaches `RUN_DIV`; the divider then resets to 0.
  - Before issuing a phase-0 cycle, two checks apply:
    - if `brk_en`, `cpu_pc`==`brk_addr` and `skip_brk`==0 → STOP with `brk_hit`=1 and no `cpu_ce`;
    - `skip_brk` clears after the first issued phase-0 cycle.
  - psw[0] in RUN:
    - if `phase`==0 and no `cpu_ce` is in flight → STOP;
    - otherwise → DRAIN.
- **DRAIN:** issues `cpu_ce` every clk, ignoring `RUN_DIV`, until `phase` returns to 0, then → STOP. Breakpoint checking is off.
- **ISTEP:** issues `cpu_ce` every clk until `phase` wraps to 0, then → STOP.
  - From `phase`=0 this is exactly `CYCLES_PER_INST` enables.
  - From `phase`=p≠0 it completes the instruction: `CYCLES_PER_INST`-p enables.
- **CSTEP:** exactly one `cpu_ce`, then → STOP.
- **HALTED:**
  - Entered from any issuing state when `cpu_halt`=1 while `phase`==0 and the next cycle would issue.
  - `cpu_ce`=0. All psw pulses except [3]/[5]/[10] are ignored.
  - Exits only on `rst`.
- **Pulses ignored by state:** psw[1]/[2] are ignored in RUN, DRAIN, ISTEP, CSTEP. psw[0] is ignored in DRAIN, ISTEP, CSTEP.
- **Breakpoint registers:** psw[3], [5], [10] act in every state.
  - [5] and [10] wrap modulo 256.
  - [5] and [10] together → no change.
  - A change to `brk_addr` or `brk_en` never clears `brk_hit`.

## Timing
- A pulse sampled at edge k changes state at edge k. The first resulting `cpu_ce` is high in cycle k+1.
- **ISTEP from `phase`=0:** `cpu_ce` is high in cycles k+1..k+`CYCLES_PER_INST`. STOP is entered at the edge that wraps `phase`. `inst_count` increments at the same edge.
- **RUN with `RUN_DIV`=D:** the first `cpu_ce` is in cycle k+D+1, then every D+1 cycles.
- **Breakpoint hit:** `brk_hit` and STOP are registered at the edge where the phase-0 issue would have occurred. `cpu_ce` stays 0.
- **Asynchronous reset mid-instruction:** all outputs take their reset values immediately. `phase` returns to 0 and no partial instruction is completed.

## Test plan
- Reset, then psw[1] pulse with `CYCLES_PER_INST`=4:
  - `cpu_ce` high for exactly 4 consecutive clks starting 1 clk after the pulse;
  - `phase` goes 0→1→2→3→0;
  - `inst_count`=1; state back to STOP.
- Three psw[2] pulses 5 clks apart, then psw[1]:
  - single `cpu_ce` per clock-step pulse, `phase`=3 after the clock steps;
  - ISTEP issues 1 enable;
  - `inst_count`=1.
- `RUN_DIV`=2, psw[0], hold for 30 clks, then psw[0] at `phase`=2:
  - `cpu_ce` every 3rd clk;
  - DRAIN issues 2 back-to-back enables;
  - STOP with `phase`=0.
- `brk_addr` set to 0x03 by three psw[5] pulses, psw[3], then psw[0] with `cpu_pc` driven as `inst_count`:
  - stops before the instruction at PC 0x03, `brk_hit`=1, `inst_count`=3;
  - a further psw[0] resumes past 0x03.
- psw[10] with `brk_addr`=0 → `brk_addr`=0xFF. psw[5] and psw[10] in the same clk → unchanged.
- `cpu_halt`=1 during RUN:
  - HALTED at the next phase-0 boundary, `cpu_ce`=0, `halted`=1;
  - psw[0]/[1]/[2] have no effect;
  - `rst` low mid-HALTED → all outputs return to reset values.
